// File: rtl/dm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_pkg : shared encodings and lane helpers for the data-memory controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    REG_NONE   = 2'd0,
    REG_STATIC = 2'd1,
    REG_HEAP   = 2'd2,
    REG_STACK  = 2'd3
  } region_e;

  // Eight lanes so that an access running past a word boundary yields the
  // upper word's enables in bits [7:4].
  function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    return mask << off;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] res;
    case (size)
      SZ_B:    res = {{24{~uns & raw[7]}}, raw[7:0]};
      SZ_H:    res = {{16{~uns & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_bank : one region's word RAM, synchronous read, per-byte write enable.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dm_bank #(
  parameter int    WORDS = 512,
  parameter string INIT  = ""
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(WORDS)-1:0] addr_i,
  input  logic [31:0]              wd_i,
  output logic [31:0]              rd_o
);

  logic [31:0] mem [WORDS];
  logic [31:0] rd_q;

  // Read-before-write: a store and a load in consecutive cycles still see
  // the new data because the write lands one edge earlier.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wd_i[8*i +: 8];
      end
      rd_q <= mem[addr_i];
    end
  end

  assign rd_o = rd_q;

endmodule
`default_nettype wire

// File: rtl/dm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_ctrl : load/store controller over static, heap and stack RAM regions.
// Define DM_MISALIGN_SPLIT_EN to run word-crossing accesses as two phases.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] STATIC_BASE  = 32'h0000_1000,
  parameter int                STATIC_WORDS = 512,
  parameter logic [ADDR_W-1:0] HEAP_BASE    = 32'h0001_0000,
  parameter int                HEAP_WORDS   = 512,
  parameter logic [ADDR_W-1:0] STACK_BASE   = 32'h0002_0000,
  parameter int                STACK_WORDS  = 512,
  parameter string             STATIC_INIT  = "",
  parameter string             HEAP_INIT    = "",
  parameter string             STACK_INIT   = ""
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wd_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rd_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] STATIC_LAST = STATIC_BASE + ADDR_W'(4 * STATIC_WORDS - 1);
  localparam logic [ADDR_W-1:0] HEAP_LAST   = HEAP_BASE + ADDR_W'(4 * HEAP_WORDS - 1);
  localparam logic [ADDR_W-1:0] STACK_LAST  = STACK_BASE + ADDR_W'(4 * STACK_WORDS - 1);
  localparam int S_IW = $clog2(STATIC_WORDS);
  localparam int H_IW = $clog2(HEAP_WORDS);
  localparam int K_IW = $clog2(STACK_WORDS);
`ifdef DM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  function automatic region_e region_of(input logic [ADDR_W-1:0] a);
    region_e r;
    r = REG_NONE;
    if (a >= STATIC_BASE && a <= STATIC_LAST)    r = REG_STATIC;
    else if (a >= HEAP_BASE && a <= HEAP_LAST)   r = REG_HEAP;
    else if (a >= STACK_BASE && a <= STACK_LAST) r = REG_STACK;
    return r;
  endfunction

  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] last_addr;
  region_e           reg_first, reg_last, cur_reg;
  logic              misaligned, crosses, acc_err, accept, split_start, in_split, active;
  logic [7:0]        be8;
  logic [63:0]       wd_sh;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        cur_be;
  logic [31:0]       cur_wd, static_rd, heap_rd, stack_rd, bank_rd, lo_word, hi_word;

  logic              rdy_q, rvalid_q, err_q, rwe_q, runs_q, rsplit_q;
  logic              rdy_d, rvalid_d, err_d, rwe_d, runs_d, rsplit_d;
  logic [1:0]        rsize_q, roff_q, rsize_d, roff_d;
  region_e           rreg_q, pend_reg_q, rreg_d, pend_reg_d;
  logic [31:0]       hold_q, wd_hi_q, hold_d, wd_hi_d;
  logic [3:0]        be_hi_q, be_hi_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;

  always_comb begin
    case (size_i)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign last_addr   = addr_i + ADDR_W'(nbytes - 3'd1);
  assign reg_first   = region_of(addr_i);
  assign reg_last    = region_of(last_addr);
  assign misaligned  = (size_i == SZ_H && addr_i[0]) || (size_i == SZ_W && addr_i[1:0] != 2'b00);
  assign crosses     = ({1'b0, addr_i[1:0]} + nbytes) > 3'd4;
  assign acc_err     = (reg_first == REG_NONE) || (reg_first != reg_last) || (size_i == 2'b11) ||
                       (misaligned && !SPLIT_EN);
  assign accept      = req_i && gnt_o;
  assign split_start = accept && !acc_err && crosses;
  assign be8         = be_gen(size_i, addr_i[1:0]);
  assign wd_sh       = {32'h0, wd_i} << {addr_i[1:0], 3'b000};

`ifdef DM_MISALIGN_SPLIT_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;
  logic [0:0] state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (split_start) state_d = ST_SPLIT;
      ST_SPLIT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_split = (state_q == ST_SPLIT);
    gnt_o    = rdy_q && !in_split;
  end
`else
  always_comb begin
    in_split = 1'b0;
    gnt_o    = rdy_q;
  end
`endif

  // During SPLIT the banks see the captured upper word, otherwise the request.
  always_comb begin
    if (in_split) begin
      cur_addr = next_addr_q;
      cur_reg  = pend_reg_q;
      cur_be   = be_hi_q;
      cur_wd   = wd_hi_q;
      active   = 1'b1;
    end else begin
      cur_addr = addr_i;
      cur_reg  = reg_first;
      cur_be   = we_i ? be8[3:0] : 4'h0;
      cur_wd   = wd_sh[31:0];
      active   = accept && !acc_err;
    end
  end

  dm_bank #(.WORDS(STATIC_WORDS), .INIT(STATIC_INIT)) u_static (
    .clk_i (clk_i),
    .en_i  (active && cur_reg == REG_STATIC),
    .be_i  (cur_be),
    .addr_i(S_IW'((cur_addr - STATIC_BASE) >> 2)),
    .wd_i  (cur_wd),
    .rd_o  (static_rd)
  );

  dm_bank #(.WORDS(HEAP_WORDS), .INIT(HEAP_INIT)) u_heap (
    .clk_i (clk_i),
    .en_i  (active && cur_reg == REG_HEAP),
    .be_i  (cur_be),
    .addr_i(H_IW'((cur_addr - HEAP_BASE) >> 2)),
    .wd_i  (cur_wd),
    .rd_o  (heap_rd)
  );

  dm_bank #(.WORDS(STACK_WORDS), .INIT(STACK_INIT)) u_stack (
    .clk_i (clk_i),
    .en_i  (active && cur_reg == REG_STACK),
    .be_i  (cur_be),
    .addr_i(K_IW'((cur_addr - STACK_BASE) >> 2)),
    .wd_i  (cur_wd),
    .rd_o  (stack_rd)
  );

  always_comb begin
    case (rreg_q)
      REG_STATIC: bank_rd = static_rd;
      REG_HEAP:   bank_rd = heap_rd;
      REG_STACK:  bank_rd = stack_rd;
      default:    bank_rd = 32'h0;
    endcase
  end

  always_comb begin
    rdy_d       = 1'b1;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rwe_d       = rwe_q;
    runs_d      = runs_q;
    rsplit_d    = rsplit_q;
    rsize_d     = rsize_q;
    roff_d      = roff_q;
    rreg_d      = rreg_q;
    pend_reg_d  = pend_reg_q;
    hold_d      = hold_q;
    wd_hi_d     = wd_hi_q;
    be_hi_d     = be_hi_q;
    next_addr_d = next_addr_q;
    if (accept) begin
      rvalid_d = !split_start;
      err_d    = acc_err;
      rwe_d    = we_i;
      runs_d   = uns_i;
      rsplit_d = split_start;
      rsize_d  = size_i;
      roff_d   = addr_i[1:0];
      rreg_d   = reg_first;
      if (split_start) begin
        next_addr_d = {addr_i[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
        pend_reg_d  = reg_first;
        be_hi_d     = we_i ? be8[7:4] : 4'h0;
        wd_hi_d     = wd_sh[63:32];
      end
    end else if (in_split) begin
      // Lower word was read on the accepting edge; park it for the merge.
      rvalid_d = 1'b1;
      hold_d   = bank_rd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rwe_q       <= 1'b0;
      runs_q      <= 1'b0;
      rsplit_q    <= 1'b0;
      rsize_q     <= SZ_B;
      roff_q      <= 2'b00;
      rreg_q      <= REG_NONE;
      pend_reg_q  <= REG_NONE;
      hold_q      <= 32'h0;
      wd_hi_q     <= 32'h0;
      be_hi_q     <= 4'h0;
      next_addr_q <= '0;
    end else begin
      rdy_q       <= rdy_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rwe_q       <= rwe_d;
      runs_q      <= runs_d;
      rsplit_q    <= rsplit_d;
      rsize_q     <= rsize_d;
      roff_q      <= roff_d;
      rreg_q      <= rreg_d;
      pend_reg_q  <= pend_reg_d;
      hold_q      <= hold_d;
      wd_hi_q     <= wd_hi_d;
      be_hi_q     <= be_hi_d;
      next_addr_q <= next_addr_d;
    end
  end

  always_comb begin
    lo_word = rsplit_q ? hold_q : bank_rd;
    hi_word = rsplit_q ? bank_rd : 32'h0;
    rd_o    = 32'h0;
    if (rvalid_q && !err_q && !rwe_q) begin
      rd_o = load_ext(32'({hi_word, lo_word} >> {roff_q, 3'b000}), rsize_q, runs_q);
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dm_ctrl : directed and random load/store checks against a byte-array model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dm_ctrl;

  localparam logic [31:0] SBASE = 32'h0000_1000;
  localparam logic [31:0] HBASE = 32'h0001_0000;
  localparam logic [31:0] KBASE = 32'h0002_0000;
  localparam int          RBYTES = 4 * 512;

  logic        clk = 1'b0;
  logic        rst_n, req, we, uns, gnt, rvalid, err;
  logic [1:0]  size;
  logic [31:0] addr, wd, rd;

  int total = 0;
  int bad   = 0;

  logic [7:0] mmem [logic [31:0]];

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .req_i   (req),
    .we_i    (we),
    .size_i  (size),
    .uns_i   (uns),
    .addr_i  (addr),
    .wd_i    (wd),
    .gnt_o   (gnt),
    .rvalid_o(rvalid),
    .rd_o    (rd),
    .err_o   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    if (a >= SBASE && a < SBASE + RBYTES) return 1;
    if (a >= HBASE && a < HBASE + RBYTES) return 2;
    if (a >= KBASE && a < KBASE + RBYTES) return 3;
    return 0;
  endfunction

  // Reference: little-endian byte array, latency 2 only for a legal access
  // whose bytes run into the next word (split build).
  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] erd, output logic eerr,
                       output int lat);
    int n, r0, r1;
    logic mis;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis  = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    r0   = region_of(a);
    r1   = region_of(a + n - 1);
    eerr = (r0 == 0) || (r0 != r1) || (sz == 2'd3);
`ifdef DM_MISALIGN_SPLIT_EN
    lat  = (!eerr && (int'(a[1:0]) + n > 4)) ? 2 : 1;
`else
    if (mis) eerr = 1'b1;
    lat  = 1;
`endif
    erd = 32'h0;
    if (!eerr) begin
      if (w) begin
        for (int i = 0; i < n; i++) mmem[a + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[a + i];
        if (!u && n < 4 && v[8*n-1] == 1'b1) begin
          for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        end
        erd = v;
      end
    end
  endtask

  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] erd;
    logic        eerr;
    int          lat;
    model(w, sz, u, a, d, erd, eerr, lat);
    @(negedge clk);
    chk({tag, ":gnt"}, 32'(gnt), 32'd1);
    chk({tag, ":quiet"}, 32'(rvalid), 32'd0);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wd = d;
    @(negedge clk);
    req = 1'b0;
    if (lat == 2) begin
      chk({tag, ":split_gnt"}, 32'(gnt), 32'd0);
      chk({tag, ":split_rv"}, 32'(rvalid), 32'd0);
      @(negedge clk);
    end
    chk({tag, ":rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ":err"}, 32'(err), 32'(eerr));
    chk({tag, ":rd"}, rd, erd);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    int k;
    case ($urandom_range(0, 2))
      0:       base = SBASE;
      1:       base = HBASE;
      default: base = KBASE;
    endcase
    k = int'($urandom_range(0, 9));
    if (k < 4) return base + $urandom_range(0, 31);
    if (k < 8) return base + RBYTES - 32 + $urandom_range(0, 31);
    if (k == 8) return base - $urandom_range(1, 3);
    return 32'h500 + $urandom_range(0, 255);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] erd1, erd2;
    logic        e1, e2;
    int          l1, l2, r;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wd = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst:gnt", 32'(gnt), 32'd0);
    chk("rst:rvalid", 32'(rvalid), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:rd", rd, 32'd0);
    rst_n = 1'b1;

    access("sw1000", 1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF);
    access("lw1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    access("sb1001", 1'b1, 2'd0, 1'b0, 32'h1001, 32'h0000007F);
    access("lb1001", 1'b0, 2'd0, 1'b0, 32'h1001, 32'h0);
    access("lb1003", 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0);
    access("lhu1002", 1'b0, 2'd1, 1'b1, 32'h1002, 32'h0);
    access("lw_noreg", 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    access("lw_unchanged", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    access("sw_heapend", 1'b1, 2'd2, 1'b0, HBASE + RBYTES - 4, 32'h55667788);
    access("sw_span", 1'b1, 2'd2, 1'b0, HBASE + RBYTES - 2, 32'hCAFEF00D);
    access("lw_span", 1'b0, 2'd2, 1'b0, HBASE + RBYTES - 2, 32'h0);
    access("lh_heapend", 1'b0, 2'd1, 1'b0, HBASE + RBYTES - 2, 32'h0);
    access("sw1004", 1'b1, 2'd2, 1'b0, 32'h1004, 32'h0);
    access("sw_mis", 1'b1, 2'd2, 1'b0, 32'h1003, 32'h11223344);
    access("lw1000b", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    access("lw1004", 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);
    access("size11", 1'b0, 2'd3, 1'b0, 32'h1000, 32'h0);
    access("lh_off1", 1'b0, 2'd1, 1'b0, 32'h1001, 32'h0);
    access("lhu_off3", 1'b0, 2'd1, 1'b1, 32'h1003, 32'h0);
    access("sh_off3", 1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000ABCD);
    access("lw_mis", 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);

    // Reset lands in the cycle after acceptance of a word-crossing load.
    @(negedge clk);
    chk("rstmid:gnt_pre", 32'(gnt), 32'd1);
    req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h1003;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid:gnt", 32'(gnt), 32'd0);
    chk("rstmid:rvalid", 32'(rvalid), 32'd0);
    chk("rstmid:rd", rd, 32'd0);
    @(negedge clk);
    chk("rstmid:rvalid2", 32'(rvalid), 32'd0);
    chk("rstmid:gnt2", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid:rvalid3", 32'(rvalid), 32'd0);
    access("lw_post_rst", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);

    // Known contents in the windows the random phase draws from.
    for (int i = 0; i < 9; i++) begin
      access("fill_s", 1'b1, 2'd2, 1'b0, SBASE + 32'(4 * i), $urandom);
      access("fill_h", 1'b1, 2'd2, 1'b0, HBASE + 32'(4 * i), $urandom);
      access("fill_k", 1'b1, 2'd2, 1'b0, KBASE + 32'(4 * i), $urandom);
    end
    for (int i = 1; i <= 8; i++) begin
      access("fill_se", 1'b1, 2'd2, 1'b0, SBASE + RBYTES - 32'(4 * i), $urandom);
      access("fill_he", 1'b1, 2'd2, 1'b0, HBASE + RBYTES - 32'(4 * i), $urandom);
      access("fill_ke", 1'b1, 2'd2, 1'b0, KBASE + RBYTES - 32'(4 * i), $urandom);
    end

    // Store then load of the same word on consecutive edges.
    model(1'b1, 2'd2, 1'b0, HBASE + 8, 32'hA5C3_0F96, erd1, e1, l1);
    model(1'b0, 2'd2, 1'b0, HBASE + 8, 32'h0, erd2, e2, l2);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = HBASE + 8; wd = 32'hA5C3_0F96;
    @(negedge clk);
    chk("b2b:st_rvalid", 32'(rvalid), 32'd1);
    chk("b2b:st_err", 32'(err), 32'(e1));
    chk("b2b:st_rd", rd, erd1);
    chk("b2b:gnt", 32'(gnt), 32'd1);
    we = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("b2b:ld_rvalid", 32'(rvalid), 32'd1);
    chk("b2b:ld_err", 32'(err), 32'(e2));
    chk("b2b:ld_rd", rd, erd2);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      access("rand", 1'($urandom_range(0, 1)), (r == 9) ? 2'd3 : 2'(r % 3),
             1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
